// File: rtl/note_judge.sv
// Per-lane hit/miss timing judge: compares button edges against note-arrival
// strobes, holds per-lane feedback, and keeps saturating hit/miss totals.
module note_judge #(
  parameter logic [23:0] WINDOW_CYCLES = 24'd5_000_000,
  parameter logic [23:0] HOLD_CYCLES   = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  btn,
  input  logic [7:0]  note_arrive,
  output logic [7:0]  noteAction,
  output logic [7:0]  noteSuccessState,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {IDLE, WINDOW, RESULT} state_t;

  logic [7:0]  btn_q;
  logic [7:0]  press;
  logic [7:0]  hit_ev;
  logic [7:0]  miss_ev;
  logic [3:0]  hit_pop;
  logic [3:0]  miss_pop;
  logic [16:0] hit_sum;
  logic [16:0] miss_sum;
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Reset to all-ones so a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 8'hFF;
    else     btn_q <= btn;
  end

  assign press = btn & ~btn_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      state_t      state_q;
      logic [23:0] cnt_q;
      logic        success_q;

      // A displacing arrival outranks a press, and a press outranks timeout.
      assign hit_ev[gi]  = (state_q == WINDOW) && !note_arrive[gi] && press[gi];
      assign miss_ev[gi] = (state_q == WINDOW) &&
                           (note_arrive[gi] || (!press[gi] && cnt_q == 24'd0));

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q   <= IDLE;
          cnt_q     <= 24'd0;
          success_q <= 1'b0;
        end else begin
          unique case (state_q)
            IDLE: begin
              if (note_arrive[gi]) begin
                state_q <= WINDOW;
                cnt_q   <= WINDOW_CYCLES - 24'd1;
              end
            end
            WINDOW: begin
              if (note_arrive[gi]) begin
                cnt_q <= WINDOW_CYCLES - 24'd1;
              end else if (press[gi]) begin
                state_q   <= RESULT;
                success_q <= 1'b1;
                cnt_q     <= HOLD_CYCLES - 24'd1;
              end else if (cnt_q == 24'd0) begin
                state_q   <= RESULT;
                success_q <= 1'b0;
                cnt_q     <= HOLD_CYCLES - 24'd1;
              end else begin
                cnt_q <= cnt_q - 24'd1;
              end
            end
            RESULT: begin
              if (note_arrive[gi]) begin
                state_q <= WINDOW;
                cnt_q   <= WINDOW_CYCLES - 24'd1;
              end else if (cnt_q == 24'd0) begin
                state_q <= IDLE;
              end else begin
                cnt_q <= cnt_q - 24'd1;
              end
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= 24'd0;
            end
          endcase
        end
      end

      assign noteAction[gi]       = (state_q == RESULT);
      assign noteSuccessState[gi] = success_q & (state_q == RESULT);
    end
  endgenerate

  always_comb begin
    hit_pop  = 4'd0;
    miss_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      hit_pop  = hit_pop + 4'(hit_ev[i]);
      miss_pop = miss_pop + 4'(miss_ev[i]);
    end
  end

  // Sums are formed one bit wider so overflow can clamp instead of wrap.
  assign hit_sum      = {1'b0, hit_count_q} + {13'd0, hit_pop};
  assign miss_sum     = {1'b0, miss_count_q} + {13'd0, miss_pop};
  assign hit_count_d  = hit_sum[16]  ? 16'hFFFF : hit_sum[15:0];
  assign miss_count_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: a timestamp-based lane model predicts the
// outputs after every clock edge; a monitor pops and compares them.
module tb_note_judge;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  btn = 8'h00;
  logic [7:0]  note_arrive = 8'h00;
  logic [7:0]  noteAction;
  logic [7:0]  noteSuccessState;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  note_judge #(.WINDOW_CYCLES(24'(W)), .HOLD_CYCLES(24'(H))) dut (
    .clk(clk), .rst(rst), .btn(btn), .note_arrive(note_arrive),
    .noteAction(noteAction), .noteSuccessState(noteSuccessState),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0]  na;
    logic [7:0]  ns;
    logic [15:0] hc;
    logic [15:0] mc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: each lane is idle, waiting for a press until an absolute deadline,
  // or showing feedback until an absolute deadline.
  int         mode [8];   // 0 idle, 1 awaiting press, 2 showing feedback
  longint     dl   [8];
  bit         succ [8];
  int         hc_m, mc_m;
  logic [7:0] prev_btn;
  longint     t = 0;

  task automatic model_eval();
    exp_t e;
    int   h, m;
    logic [7:0] pr;
    t++;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin mode[i] = 0; dl[i] = 0; succ[i] = 0; end
      hc_m = 0; mc_m = 0; prev_btn = 8'hFF;
    end else begin
      pr = btn & ~prev_btn;
      prev_btn = btn;
      h = 0; m = 0;
      for (int i = 0; i < 8; i++) begin
        case (mode[i])
          0: if (note_arrive[i]) begin mode[i] = 1; dl[i] = t + W; end
          1: begin
            if (note_arrive[i]) begin m++; dl[i] = t + W; end
            else if (pr[i]) begin h++; mode[i] = 2; succ[i] = 1; dl[i] = t + H; end
            else if (t == dl[i]) begin m++; mode[i] = 2; succ[i] = 0; dl[i] = t + H; end
          end
          default: begin
            if (note_arrive[i]) begin mode[i] = 1; dl[i] = t + W; end
            else if (t == dl[i]) mode[i] = 0;
          end
        endcase
      end
      hc_m = (hc_m + h > 65535) ? 65535 : hc_m + h;
      mc_m = (mc_m + m > 65535) ? 65535 : mc_m + m;
    end
    for (int i = 0; i < 8; i++) begin
      e.na[i] = (mode[i] == 2);
      e.ns[i] = (mode[i] == 2) && succ[i];
    end
    e.hc = 16'(hc_m);
    e.mc = 16'(mc_m);
    q.push_back(e);
  endtask

  task automatic step(input logic [7:0] b, input logic [7:0] a, input logic r);
    @(negedge clk);
    btn = b; note_arrive = a; rst = r;
    model_eval();
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step(btn, 8'h00, 1'b0);
  endtask

  // Monitor: one comparison per clock edge that has a prediction queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (noteAction !== e.na || noteSuccessState !== e.ns ||
            hit_count !== e.hc || miss_count !== e.mc) begin
          errors++;
          $display("FAIL outputs cycle=%0d got na=%h ns=%h hit=%h miss=%h, expected na=%h ns=%h hit=%h miss=%h",
                   t, noteAction, noteSuccessState, hit_count, miss_count,
                   e.na, e.ns, e.hc, e.mc);
        end
      end
    end
  end

  initial begin
    logic [7:0] a, flip;
    step(8'h00, 8'h00, 1'b1);
    step(8'h00, 8'h00, 1'b1);
    hold(3);

    // Hit on lane 0, press two cycles after arrival.
    step(8'h00, 8'h01, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h01, 8'h00, 1'b0);
    hold(5);
    step(8'h00, 8'h00, 1'b0);

    // Miss on lane 3 with no press, then a press in the last window cycle.
    step(8'h00, 8'h08, 1'b0);
    hold(8);
    step(8'h00, 8'h08, 1'b0);
    hold(3);
    step(8'h08, 8'h00, 1'b0);
    hold(5);
    step(8'h00, 8'h00, 1'b0);

    // Early press on lane 2 held through the whole window: miss.
    step(8'h04, 8'h00, 1'b0);
    hold(4);
    step(8'h04, 8'h04, 1'b0);
    hold(9);
    step(8'h00, 8'h00, 1'b0);

    // Displaced note on lane 1, then a hit on the replacement.
    step(8'h00, 8'h02, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h02, 1'b0);
    step(8'h02, 8'h00, 1'b0);
    hold(5);

    // All lanes arrive and press together.
    step(8'h00, 8'hFF, 1'b0);
    step(8'hFF, 8'h00, 1'b0);
    hold(2);

    // Reset during a feedback hold and during a window.
    step(8'hFF, 8'h00, 1'b1);
    step(8'h00, 8'hFF, 1'b0);
    hold(1);
    step(8'h00, 8'h00, 1'b1);
    // Button held high across reset release must not score a hit.
    step(8'hFF, 8'h00, 1'b1);
    step(8'hFF, 8'hFF, 1'b0);
    hold(9);
    step(8'h00, 8'h00, 1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      a = 8'h00; flip = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 15) == 0) a[i] = 1'b1;
        if ($urandom_range(0, 3) == 0) flip[i] = 1'b1;
      end
      step(btn ^ flip, a, ($urandom_range(0, 499) == 0));
    end

    // Drive hit_count to 16'hFFFC, then past the ceiling.
    step(8'h00, 8'h00, 1'b1);
    for (int r = 0; r < 8191; r++) begin
      step(8'h00, 8'hFF, 1'b0);
      step(8'hFF, 8'h00, 1'b0);
    end
    step(8'h00, 8'h0F, 1'b0);
    step(8'h0F, 8'h00, 1'b0);
    for (int r = 0; r < 2; r++) begin
      step(8'h00, 8'hFF, 1'b0);
      step(8'hFF, 8'h00, 1'b0);
    end
    hold(6);

    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
